// File: rtl/irda_mir_tx.sv
// irda_mir_tx: MIR-mode (1.152 / 0.576 Mbit/s) HDLC transmit framer.
// Builds start flags, zero-bit-stuffed payload and a stop flag (or an abort
// sequence on underrun) and emits each 0 bit as a short IR pulse at the start
// of its bit cell.
module irda_mir_tx (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       mir_mode,
  input  logic       mir_half,
  input  logic       tx_select,
  input  logic       quarter_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       mir_tx,
  output logic       tx_busy,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam logic [7:0] FLAG = 8'h7E;

  // Line value of the cell described by (state, stuff flag, shifter lsb, bit index).
  function automatic logic cell_bit(input state_t st, input logic stf,
                                    input logic sh_lsb, input logic [2:0] idx);
    logic b;
    b = 1'b1;
    case (st)
      S_START, S_STOP: b = FLAG[idx];
      S_DATA:          b = stf ? 1'b0 : sh_lsb;
      default:         b = 1'b1;
    endcase
    return b;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] q_q, q_d;               // strobe slot within the current cell
  logic       half_q, half_d;         // cell length latched at cell start
  logic [3:0] bit_cnt_q, bit_cnt_d;   // bit index within flags / byte / abort
  logic       stuff_q, stuff_d;       // current DATA cell is a stuffed 0
  logic [2:0] ones_q, ones_d;         // consecutive payload ones sent
  logic [7:0] shift_q, shift_d;       // byte being serialised, lsb is current bit
  logic       cur_last_q, cur_last_d; // byte in shifter is the frame's last
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       hold_last_q, hold_last_d;
  logic       last_seen_q, last_seen_d;
  logic       en_q;                   // enable seen for at least one clk
  logic       mir_tx_q, mir_tx_d;
  logic       busy_q, busy_d;
  logic       underrun_q, underrun_d;

  logic       enable;
  logic       cell_end;
  logic       cur_bit;
  logic       next_bit;
  logic [2:0] ones_inc;
  logic [3:0] cnt_inc;

  assign enable   = mir_mode && tx_select;
  assign cell_end = (q_q == (half_q ? 3'd7 : 3'd3));
  assign ones_inc = ones_q + 3'd1;
  assign cnt_inc  = bit_cnt_q + 4'd1;
  assign cur_bit  = cell_bit(state_q, stuff_q, shift_q[0], bit_cnt_q[2:0]);
  assign next_bit = cell_bit(state_d, stuff_d, shift_d[0], bit_cnt_d[2:0]);

  // Ready is a decode of registered state; it stays low for the first clk after
  // reset or re-enable so a byte is never taken while the framer is clearing.
  assign tx_ready = enable && en_q && !hold_valid_q && !last_seen_q &&
                    (state_q inside {S_IDLE, S_START, S_DATA});

  assign mir_tx      = mir_tx_q;
  assign tx_busy     = busy_q;
  assign tx_underrun = underrun_q;

  // State register: all flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      q_q          <= 3'd0;
      half_q       <= 1'b0;
      bit_cnt_q    <= 4'd0;
      stuff_q      <= 1'b0;
      ones_q       <= 3'd0;
      shift_q      <= 8'd0;
      cur_last_q   <= 1'b0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      last_seen_q  <= 1'b0;
      en_q         <= 1'b0;
      mir_tx_q     <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      half_q       <= half_d;
      bit_cnt_q    <= bit_cnt_d;
      stuff_q      <= stuff_d;
      ones_q       <= ones_d;
      shift_q      <= shift_d;
      cur_last_q   <= cur_last_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      last_seen_q  <= last_seen_d;
      en_q         <= enable;
      mir_tx_q     <= mir_tx_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next-state: handshake capture, cell sequencing, stuffing and byte boundaries.
  always_comb begin
    state_d      = state_q;
    q_d          = q_q;
    half_d       = half_q;
    bit_cnt_d    = bit_cnt_q;
    stuff_d      = stuff_q;
    ones_d       = ones_q;
    shift_d      = shift_q;
    cur_last_d   = cur_last_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    last_seen_d  = last_seen_q;
    underrun_d   = 1'b0;

    if (tx_valid && tx_ready) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
      hold_last_d  = tx_last;
      if (tx_last) last_seen_d = 1'b1;
    end

    if (!enable) begin
      // Losing enable abandons the frame silently and flushes everything.
      state_d      = S_IDLE;
      q_d          = 3'd0;
      bit_cnt_d    = 4'd0;
      stuff_d      = 1'b0;
      ones_d       = 3'd0;
      cur_last_d   = 1'b0;
      hold_valid_d = 1'b0;
      hold_last_d  = 1'b0;
      last_seen_d  = 1'b0;
    end else if (quarter_en) begin
      if (state_q == S_IDLE) begin
        // The strobe that leaves IDLE is slot 0 of the first flag cell.
        if (hold_valid_q) begin
          state_d   = S_START;
          q_d       = 3'd0;
          half_d    = mir_half;
          bit_cnt_d = 4'd0;
          stuff_d   = 1'b0;
          ones_d    = 3'd0;
        end
      end else if (!cell_end) begin
        q_d = q_q + 3'd1;
      end else begin
        // This strobe starts a new cell; decide what that cell carries.
        q_d    = 3'd0;
        half_d = mir_half;
        case (state_q)
          S_START: begin
            if (bit_cnt_q == 4'd15) begin
              state_d      = S_DATA;
              ones_d       = 3'd0;
              shift_d      = hold_q;
              cur_last_d   = hold_last_q;
              hold_valid_d = 1'b0;
              bit_cnt_d    = 4'd0;
              stuff_d      = 1'b0;
            end else begin
              bit_cnt_d = cnt_inc;
            end
          end
          S_DATA: begin
            if (!stuff_q && cur_bit && (ones_inc == 3'd5)) begin
              // Fifth consecutive one: insert a 0 without consuming data.
              stuff_d = 1'b1;
              ones_d  = 3'd0;
            end else begin
              stuff_d = 1'b0;
              ones_d  = (!stuff_q && cur_bit) ? ones_inc : 3'd0;
              if (bit_cnt_q == 4'd7) begin
                if (cur_last_q) begin
                  state_d   = S_STOP;
                  bit_cnt_d = 4'd0;
                end else if (hold_valid_q) begin
                  shift_d      = hold_q;
                  cur_last_d   = hold_last_q;
                  hold_valid_d = 1'b0;
                  bit_cnt_d    = 4'd0;
                end else begin
                  state_d    = S_ABORT;
                  bit_cnt_d  = 4'd0;
                  underrun_d = 1'b1;
                end
              end else begin
                bit_cnt_d = cnt_inc;
                shift_d   = {1'b0, shift_q[7:1]};
              end
            end
          end
          S_STOP, S_ABORT: begin
            if (bit_cnt_q == 4'd7) begin
              state_d     = S_IDLE;
              bit_cnt_d   = 4'd0;
              last_seen_d = 1'b0;
            end else begin
              bit_cnt_d = cnt_inc;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Output decode: pulse in the first slot (two slots at half speed) of 0 cells.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    mir_tx_d = mir_tx_q;
    if (!enable) begin
      mir_tx_d = 1'b0;
    end else if (quarter_en) begin
      mir_tx_d = (state_d != S_IDLE) && !next_bit &&
                 ((q_d == 3'd0) || (half_d && (q_d == 3'd1)));
    end
  end

endmodule
